// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle for one pipeline stage boundary.
// The master side feeds the stage and consumes its output; the slave side is the stage itself.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage register with a one-deep skid entry, flush-to-bubble and a saturating stall counter.
// Control is zeroed whenever an entry is empty, so downstream always decodes a NOP on a bubble.
module pipe_stage_skid #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               clr,
  pipe_stage_skid_if.slave  bus
);

  localparam logic [CNT_W-1:0] StallMax = '1;

  logic              outValid;
  logic [CTRL_W-1:0] outCtrl;
  logic [DATA_W-1:0] outData;
  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CNT_W-1:0]  stallCnt;
  logic              inReady;
  logic              inFire;
  logic              outFire;

  // Readiness depends only on our own skid state and flush, keeping out_ready off the upstream path.
  assign inReady = !skidValid && !bus.flush;
  assign inFire  = bus.in_valid && inReady;
  assign outFire = outValid && bus.out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      outValid  <= 1'b0;
      outCtrl   <= '0;
      outData   <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      skidData  <= '0;
    end else if (bus.flush) begin
      outValid  <= 1'b0;
      outCtrl   <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
    end else if (skidValid) begin
      if (bus.out_ready) begin
        outValid  <= 1'b1;
        outCtrl   <= skidCtrl;
        outData   <= skidData;
        skidValid <= 1'b0;
        skidCtrl  <= '0;
      end
    end else if (inFire) begin
      if (!outValid || bus.out_ready) begin
        outValid <= 1'b1;
        outCtrl  <= bus.in_ctrl;
        outData  <= bus.in_data;
      end else begin
        skidValid <= 1'b1;
        skidCtrl  <= bus.in_ctrl;
        skidData  <= bus.in_data;
      end
    end else if (outFire) begin
      outValid <= 1'b0;
      outCtrl  <= '0;
    end
  end

  // Stall cycles keep counting through flushes; only clr brings the counter back to zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stallCnt <= '0;
    end else if (outValid && !bus.out_ready && stallCnt != StallMax) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_ctrl  = outCtrl;
  assign bus.out_data  = outData;
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: a queue-based model of the stage plus directed scenarios with literal expectations.
// Two instances share stimulus: default widths, and a 4-bit stall counter to reach saturation quickly.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         flush = 1'b0;
  logic         inValid = 1'b0;
  logic [23:0]  inCtrl = '0;
  logic [159:0] inData = '0;
  logic         outReady = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0]  c;
    logic [159:0] d;
  } entry_t;

  entry_t       modelQ[$];
  logic [159:0] modelData = '0;
  int           modelStall16 = 0;
  int           modelStall4 = 0;
  bit           modelAccept;

  pipe_stage_skid_if #(.CTRL_W(24), .DATA_W(160), .CNT_W(16)) busMain ();
  pipe_stage_skid_if #(.CTRL_W(24), .DATA_W(160), .CNT_W(4))  busSmall ();

  assign busMain.flush      = flush;
  assign busMain.in_valid   = inValid;
  assign busMain.in_ctrl    = inCtrl;
  assign busMain.in_data    = inData;
  assign busMain.out_ready  = outReady;
  assign busSmall.flush     = flush;
  assign busSmall.in_valid  = inValid;
  assign busSmall.in_ctrl   = inCtrl;
  assign busSmall.in_data   = inData;
  assign busSmall.out_ready = outReady;

  pipe_stage_skid #(.CTRL_W(24), .DATA_W(160), .CNT_W(16)) dutMain (
    .clk (clk),
    .clr (clr),
    .bus (busMain.slave)
  );

  pipe_stage_skid #(.CTRL_W(24), .DATA_W(160), .CNT_W(4)) dutSmall (
    .clk (clk),
    .clr (clr),
    .bus (busSmall.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] mkData(input logic [23:0] c);
    return {c ^ 24'h5A5A5A, 112'h0, 24'hC0FFEE};
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the following rising edge.
  task automatic applyStimulus(input bit v, input logic [23:0] c, input bit r, input bit f);
    inValid  = v;
    inCtrl   = c;
    inData   = mkData(c);
    outReady = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  // Model: the stage is an ordered queue of at most two instructions, head on the output.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      modelQ.delete();
      modelData    = '0;
      modelStall16 = 0;
      modelStall4  = 0;
    end else begin
      if (modelQ.size() != 0 && !outReady) begin
        if (modelStall16 < 65535) modelStall16++;
        if (modelStall4 < 15) modelStall4++;
      end
      if (flush) begin
        modelQ.delete();
      end else begin
        modelAccept = (modelQ.size() < 2);
        if (modelQ.size() != 0 && outReady) void'(modelQ.pop_front());
        if (modelAccept && inValid) modelQ.push_back('{inCtrl, inData});
      end
      if (modelQ.size() != 0) modelData = modelQ[0].d;
    end
  end

  always @(negedge clk) begin
    if (!clr) begin
      checkOutput("model in_ready", 160'(busMain.in_ready), 160'((modelQ.size() < 2) && !flush));
      checkOutput("model out_valid", 160'(busMain.out_valid), 160'(modelQ.size() != 0));
      checkOutput("model out_ctrl", 160'(busMain.out_ctrl), 160'((modelQ.size() != 0) ? modelQ[0].c : 24'h0));
      checkOutput("model out_data", busMain.out_data, modelData);
      checkOutput("model stall_cnt", 160'(busMain.stall_cnt), 160'(modelStall16));
      checkOutput("model small out_valid", 160'(busSmall.out_valid), 160'(modelQ.size() != 0));
      checkOutput("model small stall_cnt", 160'(busSmall.stall_cnt), 160'(modelStall4));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset is asynchronous: outputs must clear before any clock edge.
    #2;
    inValid = 1'b1;
    inCtrl  = 24'hFFFFFF;
    inData  = mkData(24'hFFFFFF);
    clr     = 1'b1;
    #1;
    checkOutput("reset out_valid", 160'(busMain.out_valid), 160'(0));
    checkOutput("reset out_ctrl", 160'(busMain.out_ctrl), 160'(0));
    checkOutput("reset out_data", busMain.out_data, 160'(0));
    checkOutput("reset stall_cnt", 160'(busMain.stall_cnt), 160'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    clr     = 1'b0;
    inValid = 1'b0;
    #1;
    checkOutput("reset in_ready", 160'(busMain.in_ready), 160'(1));

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 24'(i), 1'b1, 1'b0);
      checkOutput("stream out_valid", 160'(busMain.out_valid), 160'(1));
      checkOutput("stream out_ctrl", 160'(busMain.out_ctrl), 160'(i));
    end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("stream drain out_valid", 160'(busMain.out_valid), 160'(0));

    // Back-pressure: A on output, B absorbed by skid, C waits upstream.
    applyStimulus(1'b1, 24'h00000A, 1'b1, 1'b0);
    checkOutput("bp A out_ctrl", 160'(busMain.out_ctrl), 160'(24'h00000A));
    applyStimulus(1'b1, 24'h00000B, 1'b0, 1'b0);
    checkOutput("bp stall 1", 160'(busMain.stall_cnt), 160'(1));
    checkOutput("bp in_ready low", 160'(busMain.in_ready), 160'(0));
    checkOutput("bp A held", 160'(busMain.out_ctrl), 160'(24'h00000A));
    applyStimulus(1'b1, 24'h00000C, 1'b0, 1'b0);
    checkOutput("bp stall 2", 160'(busMain.stall_cnt), 160'(2));
    applyStimulus(1'b1, 24'h00000C, 1'b0, 1'b0);
    checkOutput("bp stall 3", 160'(busMain.stall_cnt), 160'(3));
    checkOutput("bp A still held", 160'(busMain.out_ctrl), 160'(24'h00000A));
    applyStimulus(1'b1, 24'h00000C, 1'b1, 1'b0);
    checkOutput("bp B out_ctrl", 160'(busMain.out_ctrl), 160'(24'h00000B));
    checkOutput("bp in_ready high", 160'(busMain.in_ready), 160'(1));
    applyStimulus(1'b1, 24'h00000C, 1'b1, 1'b0);
    checkOutput("bp C out_ctrl", 160'(busMain.out_ctrl), 160'(24'h00000C));
    checkOutput("bp C out_data", busMain.out_data, mkData(24'h00000C));
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);

    // Flush with one entry on output and one in skid.
    applyStimulus(1'b1, 24'h000011, 1'b1, 1'b0);
    applyStimulus(1'b1, 24'h000022, 1'b0, 1'b0);
    checkOutput("flush pre skid full", 160'(busMain.in_ready), 160'(0));
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
    flush = 1'b0;
    #1;
    checkOutput("flush out_valid", 160'(busMain.out_valid), 160'(0));
    checkOutput("flush out_ctrl", 160'(busMain.out_ctrl), 160'(0));
    checkOutput("flush in_ready", 160'(busMain.in_ready), 160'(1));
    checkOutput("flush out_data held", busMain.out_data, mkData(24'h000011));
    checkOutput("flush stall kept", 160'(busMain.stall_cnt), 160'(5));

    applyStimulus(1'b1, 24'h00A5A5, 1'b1, 1'b0);
    checkOutput("bubble first ctrl", 160'(busMain.out_ctrl), 160'(24'h00A5A5));
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("bubble out_valid", 160'(busMain.out_valid), 160'(0));
    checkOutput("bubble out_ctrl", 160'(busMain.out_ctrl), 160'(0));
    checkOutput("bubble out_data held", busMain.out_data, mkData(24'h00A5A5));

    // Saturation: the 4-bit counter starts at 5 here and must stop at 15.
    applyStimulus(1'b1, 24'h000033, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 24'h000044, 1'b0, 1'b0);
    checkOutput("sat small stall_cnt", 160'(busSmall.stall_cnt), 160'(15));
    checkOutput("sat main stall_cnt", 160'(busMain.stall_cnt), 160'(25));
    clr = 1'b1;
    #1;
    checkOutput("sat clr small stall_cnt", 160'(busSmall.stall_cnt), 160'(0));
    checkOutput("sat clr main out_valid", 160'(busMain.out_valid), 160'(0));
    @(posedge clk);
    #1;
    clr = 1'b0;

    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 24'($urandom()),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
